// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic phase sequencer:
// state codes, lamp encodings and the layout of the HPS configuration word.
package traffic_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAllRedA = 3'd1,
    StNsGreen = 3'd2,
    StNsAmber = 3'd3,
    StAllRedB = 3'd4,
    StEwGreen = 3'd5,
    StEwAmber = 3'd6,
    StFlash   = 3'd7
  } state_e;

  // Lamp encoding is {red, amber, green}
  localparam logic [2:0] LampRed   = 3'b100;
  localparam logic [2:0] LampAmber = 3'b010;
  localparam logic [2:0] LampGreen = 3'b001;
  localparam logic [2:0] LampOff   = 3'b000;

  localparam int unsigned CfgRunBit      = 0;
  localparam int unsigned CfgFlashBit    = 1;
  localparam int unsigned CfgAllRedLsb   = 4;
  localparam int unsigned CfgGreenLsb    = 8;
  localparam int unsigned CfgAmberLsb    = 16;
  localparam int unsigned CfgMinGreenLsb = 24;

  function automatic logic [7:0] clamp_dur(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

  // Duration (in ticks) of a timed phase, sampled when the phase is entered.
  function automatic logic [7:0] phase_dur(input state_e     st,
                                           input logic [3:0] allred_t,
                                           input logic [7:0] green_t,
                                           input logic [7:0] amber_t);
    logic [7:0] raw;
    case (st)
      StAllRedA, StAllRedB: raw = {4'b0000, allred_t};
      StNsGreen, StEwGreen: raw = green_t;
      StNsAmber, StEwAmber: raw = amber_t;
      default:              raw = 8'd1;
    endcase
    return clamp_dur(raw);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-clock tick pulse every TICK_DIV clocks.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road traffic light sequencer with pedestrian calls, driven by an HPS
// configuration word; all phase timing is counted in prescaler ticks.
module traffic_phase_sequencer #(
  parameter int unsigned TICK_DIV    = 5000000,
  parameter int unsigned FLASH_TICKS = 5
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] cfg_word,
  input  logic [1:0]  ped_btn_n,
  output logic [2:0]  ns_light,
  output logic [2:0]  ew_light,
  output logic [1:0]  ped_walk,
  output logic [5:0]  status
);

  import traffic_pkg::*;

  localparam logic [7:0] FlashTicks = 8'(FLASH_TICKS);

  logic [1:0] rst_sync_q;
  logic       rst_n;
  logic       tick;

  logic [1:0] btn_meta_q, btn_sync_q, btn_samp_q, btn_low_q;
  logic [1:0] ped_fall;

  state_e     state_q, state_d, next_st;
  logic       enter;
  logic [7:0] elapsed_q, elapsed_d, elapsed_inc;
  logic [7:0] dur_q, dur_d, min_g_q, min_g_d;
  logic [1:0] req_q, req_d, req_pend;
  logic [1:0] walk_q, walk_d;
  logic       flash_on_q, flash_on_d;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;
  logic [5:0] status_q, status_d;

  logic       run, flash, stop, done, short_ok;
  logic [3:0] allred_t;
  logic [7:0] green_t, amber_t, min_green_t;
  logic       unused_cfg;

  assign run         = cfg_word[CfgRunBit];
  assign flash       = cfg_word[CfgFlashBit];
  assign allred_t    = cfg_word[CfgAllRedLsb +: 4];
  assign green_t     = cfg_word[CfgGreenLsb +: 8];
  assign amber_t     = cfg_word[CfgAmberLsb +: 8];
  assign min_green_t = cfg_word[CfgMinGreenLsb +: 8];
  assign unused_cfg  = ^cfg_word[3:2];
  assign stop        = !run || flash;

  // Reset asserts asynchronously but releases only after two clean clocks
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk_clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Buttons: 2-FF synchroniser, then tick-rate sampling; low on two
  // consecutive samples counts as pressed, and only the press edge registers.
  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= 2'b11;
      btn_sync_q <= 2'b11;
      btn_samp_q <= 2'b11;
      btn_low_q  <= 2'b00;
    end else begin
      btn_meta_q <= ped_btn_n;
      btn_sync_q <= btn_meta_q;
      if (tick) begin
        btn_samp_q <= btn_sync_q;
        btn_low_q  <= ~btn_samp_q & ~btn_sync_q;
      end
    end
  end

  assign ped_fall    = tick ? (~btn_samp_q & ~btn_sync_q & ~btn_low_q) : 2'b00;
  assign req_pend    = req_q | ped_fall;
  assign elapsed_inc = elapsed_q + 8'd1;
  assign done        = (elapsed_inc == dur_q);
  assign short_ok    = (min_g_q < dur_q) && (elapsed_inc >= min_g_q);

  always_comb begin
    state_d    = state_q;
    next_st    = state_q;
    enter      = 1'b0;
    elapsed_d  = elapsed_q;
    dur_d      = dur_q;
    min_g_d    = min_g_q;
    req_d      = req_pend;
    walk_d     = walk_q;
    flash_on_d = flash_on_q;

    if (tick) begin
      elapsed_d = elapsed_inc;
      case (state_q)
        StIdle: begin
          if (run) begin
            enter   = 1'b1;
            next_st = flash ? StFlash : StAllRedA;
          end
        end
        StAllRedA: begin
          if (done) begin
            enter   = 1'b1;
            next_st = !run ? StIdle : (flash ? StFlash : StNsGreen);
          end
        end
        StNsGreen: begin
          if (stop || done || (req_pend[0] && short_ok)) begin
            enter   = 1'b1;
            next_st = StNsAmber;
          end
        end
        StNsAmber: begin
          if (done) begin
            enter   = 1'b1;
            next_st = StAllRedB;
          end
        end
        StAllRedB: begin
          if (done) begin
            enter   = 1'b1;
            next_st = !run ? StIdle : (flash ? StFlash : StEwGreen);
          end
        end
        StEwGreen: begin
          if (stop || done || (req_pend[1] && short_ok)) begin
            enter   = 1'b1;
            next_st = StEwAmber;
          end
        end
        StEwAmber: begin
          if (done) begin
            enter   = 1'b1;
            next_st = StAllRedA;
          end
        end
        StFlash: begin
          if (!run) begin
            enter   = 1'b1;
            next_st = StIdle;
          end else if (!flash) begin
            enter   = 1'b1;
            next_st = StAllRedA;
          end else if (elapsed_inc == FlashTicks) begin
            elapsed_d  = 8'd0;
            flash_on_d = ~flash_on_q;
          end
        end
      endcase
    end

    if (enter) begin
      state_d    = next_st;
      elapsed_d  = 8'd0;
      dur_d      = phase_dur(next_st, allred_t, green_t, amber_t);
      min_g_d    = min_green_t;
      walk_d     = 2'b00;
      flash_on_d = (next_st == StFlash);
      // A call latched on the entry tick itself is still served by this green
      if (next_st == StNsGreen) begin
        walk_d[1] = req_pend[1];
        req_d[1]  = 1'b0;
      end
      if (next_st == StEwGreen) begin
        walk_d[0] = req_pend[0];
        req_d[0]  = 1'b0;
      end
    end
  end

  always_comb begin
    ns_d = LampRed;
    ew_d = LampRed;
    case (state_d)
      StNsGreen: ns_d = LampGreen;
      StNsAmber: ns_d = LampAmber;
      StEwGreen: ew_d = LampGreen;
      StEwAmber: ew_d = LampAmber;
      StFlash: begin
        ns_d = flash_on_d ? LampAmber : LampOff;
        ew_d = flash_on_d ? LampAmber : LampOff;
      end
      default: ;
    endcase
    status_d = {(state_d == StFlash) && flash_on_d, req_d, state_d};
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      elapsed_q  <= 8'd0;
      dur_q      <= 8'd0;
      min_g_q    <= 8'd0;
      req_q      <= 2'b00;
      walk_q     <= 2'b00;
      flash_on_q <= 1'b0;
      ns_q       <= LampRed;
      ew_q       <= LampRed;
      status_q   <= 6'd0;
    end else begin
      state_q    <= state_d;
      elapsed_q  <= elapsed_d;
      dur_q      <= dur_d;
      min_g_q    <= min_g_d;
      req_q      <= req_d;
      walk_q     <= walk_d;
      flash_on_q <= flash_on_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
      status_q   <= status_d;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign ped_walk = walk_q;
  assign status   = status_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: phase tables with hand-computed
// durations (TICK_DIV=4) plus sequences for pedestrian, stop, flash and reset.
module tb_traffic_phase_sequencer;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LA = 3'b010;
  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LO = 3'b000;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b1;
  logic [31:0] cfg_word;
  logic [1:0]  ped_btn_n;
  logic [2:0]  ns_light, ew_light;
  logic [1:0]  ped_walk;
  logic [5:0]  status;

  traffic_phase_sequencer #(
    .TICK_DIV   (4),
    .FLASH_TICKS(5)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .cfg_word     (cfg_word),
    .ped_btn_n    (ped_btn_n),
    .ns_light     (ns_light),
    .ew_light     (ew_light),
    .ped_walk     (ped_walk),
    .status       (status)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [2:0] code;
    int         clks;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [1:0] walk;
    logic [1:0] req;
  } phase_t;

  int     checks = 0;
  int     failures = 0;
  phase_t main_cycle[6];

  function automatic phase_t mk(input logic [2:0] code, input int clks, input logic [2:0] ns,
                                input logic [2:0] ew, input logic [1:0] walk,
                                input logic [1:0] req);
    phase_t p;
    p.code = code;
    p.clks = clks;
    p.ns   = ns;
    p.ew   = ew;
    p.walk = walk;
    p.req  = req;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_entry(input phase_t p, input string tag);
    chk({tag, ".state"}, {29'd0, status[2:0]}, {29'd0, p.code});
    chk({tag, ".ns"}, {29'd0, ns_light}, {29'd0, p.ns});
    chk({tag, ".ew"}, {29'd0, ew_light}, {29'd0, p.ew});
    chk({tag, ".walk"}, {30'd0, ped_walk}, {30'd0, p.walk});
    chk({tag, ".req"}, {30'd0, status[4:3]}, {30'd0, p.req});
    chk({tag, ".flash_bit"}, {31'd0, status[5]}, 32'd0);
  endtask

  // Counts negedges (from the current one) for which all outputs hold steady.
  task automatic measure(output int n);
    logic [13:0] snap;
    snap = {ns_light, ew_light, ped_walk, status};
    n = 0;
    while (({ns_light, ew_light, ped_walk, status} == snap) && (n < 400)) begin
      n++;
      @(negedge clk_clk);
    end
  endtask

  task automatic run_phase(input phase_t p, input string tag);
    int n;
    check_entry(p, tag);
    measure(n);
    chk({tag, ".clks"}, n, p.clks);
  endtask

  // Call on ped 0 at NS green entry: green cut to min_green (2 ticks),
  // then walk 0 is granted at EW green entry.
  task automatic shortened_ns(input string tag);
    run_phase(mk(3'd1, 4, LR, LR, 2'b00, 2'b00), {tag, ".allred_a"});
    ped_btn_n = 2'b10;
    run_phase(mk(3'd2, 8, LG, LR, 2'b00, 2'b00), {tag, ".ns_green"});
    ped_btn_n = 2'b11;
    run_phase(mk(3'd3, 40, LA, LR, 2'b00, 2'b01), {tag, ".ns_amber"});
    run_phase(mk(3'd4, 4, LR, LR, 2'b00, 2'b01), {tag, ".allred_b"});
    check_entry(mk(3'd5, 0, LR, LG, 2'b01, 2'b00), {tag, ".ew_green"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    main_cycle[0] = mk(3'd1, 4, LR, LR, 2'b00, 2'b00);
    main_cycle[1] = mk(3'd2, 20, LG, LR, 2'b00, 2'b00);
    main_cycle[2] = mk(3'd3, 12, LA, LR, 2'b00, 2'b00);
    main_cycle[3] = mk(3'd4, 4, LR, LR, 2'b00, 2'b00);
    main_cycle[4] = mk(3'd5, 20, LR, LG, 2'b00, 2'b00);
    main_cycle[5] = mk(3'd6, 12, LR, LA, 2'b00, 2'b00);

    cfg_word  = 32'h0203_0501;
    ped_btn_n = 2'b11;
    #1 reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    chk("reset.ns", {29'd0, ns_light}, {29'd0, LR});
    chk("reset.ew", {29'd0, ew_light}, {29'd0, LR});
    chk("reset.walk", {30'd0, ped_walk}, 32'd0);
    chk("reset.status", {26'd0, status}, 32'd0);

    // Two clocks of reset sync, then four to the first tick
    reset_reset_n = 1'b1;
    measure(n);
    chk("first_tick.clks", n, 6);

    for (int i = 0; i < 6; i++) begin
      run_phase(main_cycle[i], $sformatf("cycle%0d", i));
    end

    cfg_word = 32'h020A_0A11;
    shortened_ns("ped1");
    measure(n);
    chk("ped1.ew_green.clks", n, 40);
    run_phase(mk(3'd6, 40, LR, LA, 2'b00, 2'b00), "ped1.ew_amber");

    // run dropped during NS green elapsed 1
    run_phase(mk(3'd1, 4, LR, LR, 2'b00, 2'b00), "stop.allred_a");
    check_entry(mk(3'd2, 0, LG, LR, 2'b00, 2'b00), "stop.ns_green");
    repeat (4) @(negedge clk_clk);
    cfg_word = 32'h020A_0A10;
    measure(n);
    chk("stop.ns_green_left", n, 4);
    run_phase(mk(3'd3, 40, LA, LR, 2'b00, 2'b00), "stop.ns_amber");
    run_phase(mk(3'd4, 4, LR, LR, 2'b00, 2'b00), "stop.allred_b");
    check_entry(mk(3'd0, 0, LR, LR, 2'b00, 2'b00), "stop.idle");

    // One-sample press is ignored
    ped_btn_n = 2'b01;
    repeat (4) @(negedge clk_clk);
    ped_btn_n = 2'b11;
    repeat (12) @(negedge clk_clk);
    chk("short_press.req", {30'd0, status[4:3]}, 32'd0);

    // Long hold gives one request, served once, not re-armed while held
    ped_btn_n = 2'b01;
    repeat (40) @(negedge clk_clk);
    chk("hold.req", {30'd0, status[4:3]}, 32'd2);
    cfg_word = 32'h020A_0A11;
    measure(n);
    chk("hold.idle_left", n, 4);
    run_phase(mk(3'd1, 4, LR, LR, 2'b00, 2'b10), "hold.allred_a");
    run_phase(mk(3'd2, 40, LG, LR, 2'b10, 2'b00), "hold.ns_green");
    cfg_word  = 32'h020A_0A10;
    ped_btn_n = 2'b11;
    run_phase(mk(3'd3, 40, LA, LR, 2'b00, 2'b00), "hold.ns_amber");
    run_phase(mk(3'd4, 4, LR, LR, 2'b00, 2'b00), "hold.allred_b");
    check_entry(mk(3'd0, 0, LR, LR, 2'b00, 2'b00), "hold.idle");

    // Flash: amber on/off every 5 ticks, starting on
    cfg_word = 32'h020A_0A13;
    measure(n);
    chk("flash.idle_left", n, 4);
    for (int k = 0; k < 5; k++) begin
      logic [2:0] lamp;
      logic       on;
      on   = (k % 2 == 0);
      lamp = on ? LA : LO;
      chk($sformatf("flash%0d.ns", k), {29'd0, ns_light}, {29'd0, lamp});
      chk($sformatf("flash%0d.ew", k), {29'd0, ew_light}, {29'd0, lamp});
      chk($sformatf("flash%0d.status", k), {26'd0, status}, {26'd0, on, 2'b00, 3'd7});
      if (k == 4) cfg_word = 32'h020A_0A11;
      measure(n);
      chk($sformatf("flash%0d.clks", k), n, (k == 4) ? 4 : 20);
    end

    // Async reset in the middle of a walk phase
    shortened_ns("ped2");
    repeat (6) @(negedge clk_clk);
    reset_reset_n = 1'b0;
    #1;
    chk("midreset.ns", {29'd0, ns_light}, {29'd0, LR});
    chk("midreset.ew", {29'd0, ew_light}, {29'd0, LR});
    chk("midreset.walk", {30'd0, ped_walk}, 32'd0);
    chk("midreset.status", {26'd0, status}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
